// File: rtl/imm_operand_stage.sv
// Registered immediate-operand stage between ID and EX.
// Decodes, sign-extends and buffers immediates behind a two-entry skid.
module imm_operand_stage #(
  parameter int XLEN        = 32,
  parameter int TAG_W       = 32,
  parameter bit AUTO_DECODE = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [2:0]       in_type,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal
);

  localparam logic [2:0] ITYPE = 3'd2;
  localparam logic [2:0] STYPE = 3'd3;
  localparam logic [2:0] BTYPE = 3'd4;
  localparam logic [2:0] UTYPE = 3'd5;
  localparam logic [2:0] JTYPE = 3'd6;

  localparam logic [6:0] OP_IMM  = 7'b0010011;
  localparam logic [6:0] OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_SYS  = 7'b1110011;
  localparam logic [6:0] OP_ST   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_LUI  = 7'b0110111;
  localparam logic [6:0] OP_AUI  = 7'b0010111;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_REG  = 7'b0110011;

  typedef enum logic [2:0] {
    K_I, K_S, K_B, K_U, K_J, K_R, K_X
  } kind_t;

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [TAG_W-1:0] tag;
    logic             illegal;
  } ent_t;

  kind_t     kind;
  logic      s;
  logic [XLEN-1:0] imm;
  ent_t      new_e;
  ent_t      out_q;
  ent_t      skid_q;
  logic      skid_valid;
  logic      accept;
  logic      unused_in;

  assign unused_in = ^{in_type, in_instr[6:0]};
  assign s         = in_instr[31];

  // Immediate format: opcode lookup or explicit type code.
  always_comb begin
    kind = K_X;
    if (AUTO_DECODE) begin
      case (in_instr[6:0])
        OP_IMM, OP_LOAD,
        OP_JALR, OP_SYS:  kind = K_I;
        OP_ST:            kind = K_S;
        OP_BR:            kind = K_B;
        OP_LUI, OP_AUI:   kind = K_U;
        OP_JAL:           kind = K_J;
        OP_REG:           kind = K_R;
        default:          kind = K_X;
      endcase
    end else begin
      case (in_type)
        ITYPE:   kind = K_I;
        STYPE:   kind = K_S;
        BTYPE:   kind = K_B;
        UTYPE:   kind = K_U;
        JTYPE:   kind = K_J;
        default: kind = K_X;
      endcase
    end
  end

  // Sign-extended immediate; R and unknown formats yield zero.
  always_comb begin
    imm = '0;
    unique case (kind)
      K_I: imm = {{(XLEN-11){s}},
                  in_instr[30:20]};
      K_S: imm = {{(XLEN-11){s}},
                  in_instr[30:25],
                  in_instr[11:7]};
      K_B: imm = {{(XLEN-12){s}},
                  in_instr[7],
                  in_instr[30:25],
                  in_instr[11:8],
                  1'b0};
      K_U: imm = {{(XLEN-31){s}},
                  in_instr[30:12],
                  12'h000};
      K_J: imm = {{(XLEN-20){s}},
                  in_instr[19:12],
                  in_instr[20],
                  in_instr[30:21],
                  1'b0};
      default: imm = '0;
    endcase
  end

  assign new_e.imm     = imm;
  assign new_e.tag     = in_tag;
  assign new_e.illegal = (kind == K_X);

  assign in_ready    = !skid_valid;
  assign accept      = in_valid && in_ready;
  assign out_imm     = out_q.imm;
  assign out_tag     = out_q.tag;
  assign out_illegal = out_q.illegal;

  // Output register plus skid entry, kept in FIFO order.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
      out_q      <= '0;
      skid_q     <= '0;
    end else if (flush) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (!out_valid || out_ready) begin
      if (skid_valid) begin
        out_q      <= skid_q;
        out_valid  <= 1'b1;
        skid_valid <= 1'b0;
      end else begin
        out_valid <= accept;
        if (accept) out_q <= new_e;
      end
    end else if (accept) begin
      skid_q     <= new_e;
      skid_valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_imm_operand_stage.sv
// Bench for imm_operand_stage: three configs fed one stream,
// checked against a queue-based reference model.
module tb_imm_operand_stage;

  localparam logic [2:0] TI = 3'd2;
  localparam logic [2:0] TS = 3'd3;
  localparam logic [2:0] TB = 3'd4;
  localparam logic [2:0] TU = 3'd5;
  localparam logic [2:0] TJ = 3'd6;
  localparam logic [2:0] TX = 3'd7;
  localparam logic [2:0] T0 = 3'd0;

  typedef struct {
    logic [63:0] imm_a;
    logic        ill_a;
    logic [63:0] imm_m;
    logic        ill_m;
    logic [31:0] tag;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_instr = '0;
  logic [2:0]  in_type = '0;
  logic [31:0] in_tag = '0;

  logic        r0, r1, r2;
  logic        v0, v1, v2;
  logic [31:0] imm0, imm2;
  logic [63:0] imm1;
  logic [31:0] tag0, tag1, tag2;
  logic        ill0, ill1, ill2;

  exp_t q[$];
  bit   armed = 1'b0;
  bit   post_rst = 1'b0;
  int   n_chk = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  imm_operand_stage #(.XLEN(32), .TAG_W(32), .AUTO_DECODE(1'b1)) dut0 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(r0),
    .in_instr(in_instr), .in_type(in_type), .in_tag(in_tag),
    .out_valid(v0), .out_ready(out_ready),
    .out_imm(imm0), .out_tag(tag0), .out_illegal(ill0)
  );

  imm_operand_stage #(.XLEN(64), .TAG_W(32), .AUTO_DECODE(1'b1)) dut1 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(r1),
    .in_instr(in_instr), .in_type(in_type), .in_tag(in_tag),
    .out_valid(v1), .out_ready(out_ready),
    .out_imm(imm1), .out_tag(tag1), .out_illegal(ill1)
  );

  imm_operand_stage #(.XLEN(32), .TAG_W(32), .AUTO_DECODE(1'b0)) dut2 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(r2),
    .in_instr(in_instr), .in_type(in_type), .in_tag(in_tag),
    .out_valid(v2), .out_ready(out_ready),
    .out_imm(imm2), .out_tag(tag2), .out_illegal(ill2)
  );

  task automatic chk(input string name,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // kinds: 0 I, 1 S, 2 B, 3 U, 4 J, 5 R, 6 unknown
  function automatic int auto_kind(input logic [6:0] op);
    case (op)
      7'h13, 7'h03, 7'h67, 7'h73: return 0;
      7'h23: return 1;
      7'h63: return 2;
      7'h37, 7'h17: return 3;
      7'h6F: return 4;
      7'h33: return 5;
      default: return 6;
    endcase
  endfunction

  function automatic int man_kind(input logic [2:0] ty);
    case (ty)
      TI: return 0;
      TS: return 1;
      TB: return 2;
      TU: return 3;
      TJ: return 4;
      default: return 6;
    endcase
  endfunction

  function automatic logic [63:0] sx(input logic [63:0] v, input int n);
    logic signed [63:0] t;
    t = $signed(v << (64 - n));
    return t >>> (64 - n);
  endfunction

  function automatic logic [63:0] imm_of(input int k, input logic [31:0] i);
    case (k)
      0: return sx({52'd0, i[31:20]}, 12);
      1: return sx({52'd0, i[31:25], i[11:7]}, 12);
      2: return sx({51'd0, i[31], i[7], i[30:25], i[11:8], 1'b0}, 13);
      3: return sx({32'd0, i[31:12], 12'h000}, 32);
      4: return sx({43'd0, i[31], i[19:12], i[20], i[30:21], 1'b0}, 21);
      default: return 64'd0;
    endcase
  endfunction

  function automatic exp_t mk(input logic [31:0] ins,
                              input logic [2:0]  ty,
                              input logic [31:0] tg);
    exp_t e;
    int   ka;
    int   km;
    ka = auto_kind(ins[6:0]);
    km = man_kind(ty);
    e.imm_a = imm_of(ka, ins);
    e.ill_a = (ka == 6);
    e.imm_m = imm_of(km, ins);
    e.ill_m = (km == 6);
    e.tag   = tg;
    return e;
  endfunction

  task automatic check_outputs();
    logic rdy;
    logic vld;
    exp_t e;
    rdy = (q.size() < 2);
    vld = (q.size() > 0);
    chk("rdy0", {63'd0, r0}, {63'd0, rdy});
    chk("rdy1", {63'd0, r1}, {63'd0, rdy});
    chk("rdy2", {63'd0, r2}, {63'd0, rdy});
    chk("vld0", {63'd0, v0}, {63'd0, vld});
    chk("vld1", {63'd0, v1}, {63'd0, vld});
    chk("vld2", {63'd0, v2}, {63'd0, vld});
    if (vld) begin
      e = q[0];
      chk("imm0", {32'd0, imm0}, {32'd0, e.imm_a[31:0]});
      chk("imm1", imm1, e.imm_a);
      chk("imm2", {32'd0, imm2}, {32'd0, e.imm_m[31:0]});
      chk("tag0", {32'd0, tag0}, {32'd0, e.tag});
      chk("tag1", {32'd0, tag1}, {32'd0, e.tag});
      chk("tag2", {32'd0, tag2}, {32'd0, e.tag});
      chk("ill0", {63'd0, ill0}, {63'd0, e.ill_a});
      chk("ill1", {63'd0, ill1}, {63'd0, e.ill_a});
      chk("ill2", {63'd0, ill2}, {63'd0, e.ill_m});
    end
    if (post_rst) begin
      chk("rst_imm0", {32'd0, imm0}, 64'd0);
      chk("rst_imm1", imm1, 64'd0);
      chk("rst_tag0", {32'd0, tag0}, 64'd0);
      chk("rst_ill0", {63'd0, ill0}, 64'd0);
      chk("rst_ill2", {63'd0, ill2}, 64'd0);
    end
  endtask

  task automatic cyc(input logic r, input logic f, input logic v,
                     input logic [31:0] ins, input logic [2:0] ty,
                     input logic [31:0] tg, input logic ordy);
    bit mready;
    @(negedge clk);
    if (armed) check_outputs();
    rst       = r;
    flush     = f;
    in_valid  = v;
    in_instr  = ins;
    in_type   = ty;
    in_tag    = tg;
    out_ready = ordy;
    @(posedge clk);
    mready = (q.size() < 2);
    if (r) begin
      q.delete();
      armed    = 1'b1;
      post_rst = 1'b1;
    end else if (f) begin
      q.delete();
      post_rst = 1'b0;
    end else begin
      post_rst = 1'b0;
      if (q.size() > 0 && ordy) void'(q.pop_front());
      if (v && mready) q.push_back(mk(ins, ty, tg));
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++)
      cyc(1'b0, 1'b0, 1'b0, 32'd0, T0, 32'd0, 1'b1);
  endtask

  logic [6:0] ops [10] = '{7'h13, 7'h03, 7'h67, 7'h73, 7'h23,
                           7'h63, 7'h37, 7'h17, 7'h6F, 7'h33};

  initial begin
    logic [31:0] rnd;
    logic [6:0]  op;
    cyc(1'b1, 1'b0, 1'b0, 32'd0, T0, 32'd0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 32'd0, T0, 32'd0, 1'b0);

    cyc(1'b0, 1'b0, 1'b1, 32'hFFF00093, TI, 32'd1, 1'b1);
    cyc(1'b0, 1'b0, 1'b1, 32'hFE112E23, TS, 32'd2, 1'b1);
    cyc(1'b0, 1'b0, 1'b1, 32'hFF9FF06F, TJ, 32'd3, 1'b1);
    cyc(1'b0, 1'b0, 1'b1, 32'h123452B7, TU, 32'd4, 1'b1);
    cyc(1'b0, 1'b0, 1'b1, 32'h800000B7, TU, 32'd5, 1'b1);
    cyc(1'b0, 1'b0, 1'b1, 32'h00000000, T0, 32'd6, 1'b1);
    idle(1);

    cyc(1'b0, 1'b0, 1'b1, 32'hFFF00093, TI, 32'd11, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 32'hFE112E23, TS, 32'd12, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 32'h123452B7, TU, 32'd13, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 32'h123452B7, TU, 32'd13, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 32'h123452B7, TU, 32'd13, 1'b1);
    cyc(1'b0, 1'b0, 1'b1, 32'h123452B7, TU, 32'd13, 1'b1);
    idle(3);

    cyc(1'b0, 1'b0, 1'b1, 32'hFF9FF06F, TJ, 32'd21, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 32'hFE112E23, TS, 32'd22, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 32'hFFF00093, TI, 32'd23, 1'b1);
    idle(3);

    cyc(1'b0, 1'b0, 1'b1, 32'hFF9FF06F, TJ, 32'd31, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 32'hFE112E23, TS, 32'd32, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 32'hFFF00093, TI, 32'd33, 1'b1);
    idle(3);

    cyc(1'b0, 1'b0, 1'b1, 32'hFFF00093, TX, 32'd41, 1'b1);
    cyc(1'b0, 1'b0, 1'b1, 32'hFE000EE3, TB, 32'd42, 1'b1);
    idle(2);

    for (int n = 0; n < 600; n++) begin
      rnd = $urandom();
      if ($urandom_range(0, 9) == 0) op = rnd[6:0];
      else op = ops[$urandom_range(0, 9)];
      cyc(($urandom_range(0, 99) == 0),
          ($urandom_range(0, 29) == 0),
          ($urandom_range(0, 3) != 0),
          {rnd[31:7], op},
          3'($urandom_range(0, 7)),
          $urandom(),
          ($urandom_range(0, 9) < 6));
    end
    idle(3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
